// File: rtl/cache_line_backing_mem.sv
// ----------------------------------------------------------------------------
// cache_line_backing_mem
//
// Backing-memory responder for the data cache refill/writeback path. It serves
// whole-line bursts, one 32-bit word per beat, and adds a fixed read latency so
// that the cache miss and stall paths see realistic timing. It handles one
// requester with one outstanding request at a time.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   req_valid    request present this cycle
//   req_write    1 = line writeback, 0 = line refill (sampled with req_valid)
//   req_addr     byte address; the offset bits inside the line are ignored
//   req_ready    high while idle; a request is taken on req_valid && req_ready
//   wdata        writeback beat data
//   wdata_valid  writeback beat present this cycle
//   rdata        refill beat data, holds the last beat while rdata_valid is low
//   rdata_valid  refill beat valid this cycle (no backpressure)
//   wr_done      one-cycle pulse once the whole writeback line is stored
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a request, req_ready high
// RD_WAIT  | refill accepted, counting down the read latency
// RD_BURST | refill beats on rdata, one per cycle, ascending word order
// WR_BURST | writeback accepted, storing one word per wdata_valid cycle
// ----------------------------------------------------------------------------
module cache_line_backing_mem #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int LINE_WORDS   = 4,
    parameter int READ_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic [31:0] wdata,
    input  logic        wdata_valid,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        wr_done
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int LB    = $clog2(LINE_WORDS);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_base;
    logic [LB-1:0]    r_beat;
    logic [LAT_W-1:0] r_lat;
    logic [31:0]      r_rdata;
    logic             r_rdata_valid;
    logic             r_wr_done;

    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [AW-1:0]    w_req_base;
    logic [AW-1:0]    w_word_idx;
    logic             w_mem_we;
    logic             w_unused_addr;

    // Word index of the line start; upper address bits fall away, so the
    // index wraps modulo the storage depth.
    assign w_req_base    = req_addr[AW+1:2] & ~AW'(LINE_WORDS - 1);
    assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};

    // Base is line aligned, so OR-ing the beat in keeps the burst in its line.
    assign w_word_idx = r_base | AW'(r_beat);

    // Reset beats a concurrent write beat: an abandoned burst keeps only the
    // beats taken on earlier edges.
    assign w_mem_we = (r_state == WR_BURST) && wdata_valid && !reset;

    assign req_ready   = (r_state == IDLE);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign wr_done     = r_wr_done;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_word_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_beat        <= '0;
            r_lat         <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_wr_done     <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (req_valid) begin
                        r_base  <= w_req_base;
                        r_lat   <= LAT_W'(READ_LATENCY - 1);
                        r_state <= req_write ? WR_BURST : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Beat 0 is loaded on the last latency edge so it appears
                    // exactly READ_LATENCY edges after acceptance.
                    if (r_lat == '0) begin
                        r_rdata       <= r_mem[w_word_idx];
                        r_rdata_valid <= 1'b1;
                        r_beat        <= r_beat + LB'(1);
                        r_state       <= RD_BURST;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                RD_BURST: begin
                    // The beat counter wraps to zero after the last word.
                    if (r_beat == '0) begin
                        r_rdata_valid <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_rdata <= r_mem[w_word_idx];
                        r_beat  <= r_beat + LB'(1);
                    end
                end
                WR_BURST: begin
                    if (wdata_valid) begin
                        r_beat <= r_beat + LB'(1);
                        if (r_beat == LB'(LINE_WORDS - 1)) begin
                            r_wr_done <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_backing_mem.sv
module tb_cache_line_backing_mem;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        req_ready;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        wr_done;

    int n_tests;
    int n_fail;

    logic [31:0] d_zero [4];
    logic [31:0] d_a    [4];
    logic [31:0] d_b    [4];
    logic [31:0] d_old  [4];
    logic [31:0] d_aa   [4];
    logic [31:0] d_mix  [4];
    logic [31:0] d_w    [4];

    cache_line_backing_mem #(
        .DEPTH_WORDS (1024),
        .LINE_WORDS  (4),
        .READ_LATENCY(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .wdata      (wdata),
        .wdata_valid(wdata_valid),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .wr_done    (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge E0. Walks edges
    // E0..E0+7: beats expected after E0+3..E0+6, idle again after E0+7.
    // With hold set, a stray write request and then a refill of 0x100 are
    // driven while the burst is still running.
    task automatic observe_refill(input logic [31:0] d [4], input string tag, input bit hold);
        logic exp_v;
        for (int j = 0; j < 8; j++) begin
            exp_v = (j >= 3 && j <= 6);
            check($sformatf("%s_valid_e%0d", tag, j), {31'd0, rdata_valid}, {31'd0, exp_v});
            check($sformatf("%s_ready_e%0d", tag, j), {31'd0, req_ready}, {31'd0, (j == 7)});
            if (exp_v) check($sformatf("%s_data%0d", tag, j - 3), rdata, d[j-3]);
            if (j == 7) check($sformatf("%s_hold_last", tag), rdata, d[3]);
            if (hold && j >= 2 && j <= 5) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200;
            end
            if (hold && j == 6) begin
                req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100;
            end
            if (j < 7) @(negedge clk);
        end
    endtask

    task automatic refill(input logic [31:0] addr, input logic [31:0] d [4], input string tag);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0;
        observe_refill(d, tag, 1'b0);
    endtask

    task automatic writeback(input logic [31:0] addr, input logic [31:0] d [4],
                             input logic [15:0] pat, input int plen, input string tag);
        int taken;
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        check({tag, "_ready_accepted"}, {31'd0, req_ready}, 32'd0);
        taken = 0;
        for (int i = 0; i < plen; i++) begin
            wdata_valid = pat[i];
            wdata       = d[taken];
            @(negedge clk);
            if (pat[i]) taken++;
            if (taken == 4) begin
                check($sformatf("%s_done_c%0d", tag, i), {31'd0, wr_done}, 32'd1);
                check($sformatf("%s_ready_c%0d", tag, i), {31'd0, req_ready}, 32'd1);
                break;
            end
            check($sformatf("%s_done_c%0d", tag, i), {31'd0, wr_done}, 32'd0);
            check($sformatf("%s_ready_c%0d", tag, i), {31'd0, req_ready}, 32'd0);
        end
        wdata_valid = 1'b0;
        wdata       = 32'h0;
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, wr_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        d_zero = '{32'h0, 32'h0, 32'h0, 32'h0};
        d_a    = '{32'h11, 32'h22, 32'h33, 32'h44};
        d_b    = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
        d_old  = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
        d_aa   = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        d_mix  = '{32'hAAAA_AAAA, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
        d_w    = '{32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003, 32'h5A5A_0004};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        wdata = 32'h0; wdata_valid = 1'b0;

        // 1: reset state, refill of untouched storage
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        check("rst_wrdone", {31'd0, wr_done}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        refill(32'h0, d_zero, "t1_rd0");

        // 2: back-to-back writeback, then refill with non-aligned address
        writeback(32'h400, d_a, 16'b1111, 4, "t2_wb");
        refill(32'h40C, d_a, "t2_rd");

        // 3: writeback with gaps 1,0,0,1,1,0,1
        writeback(32'h100, d_b, 16'b1011001, 7, "t3_wb");
        refill(32'h100, d_b, "t3_rd");

        // 4: requests during a burst are ignored; next accept on first idle cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        observe_refill(d_a, "t4_rd1", 1'b1);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        observe_refill(d_b, "t4_rd2", 1'b0);
        refill(32'h200, d_zero, "t4_rd200");

        // 5: reset on the second beat of a writeback
        writeback(32'h200, d_old, 16'b1111, 4, "t5_wbold");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        wdata_valid = 1'b1; wdata = d_aa[0];
        @(negedge clk);
        wdata = d_aa[1]; reset = 1'b1;
        @(negedge clk);
        check("t5_ready", {31'd0, req_ready}, 32'd1);
        check("t5_wrdone", {31'd0, wr_done}, 32'd0);
        check("t5_rvalid", {31'd0, rdata_valid}, 32'd0);
        reset = 1'b0; wdata_valid = 1'b0; wdata = 32'h0;
        refill(32'h200, d_mix, "t5_rd");

        // reset together with req_valid: request is not taken
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_req_rvalid", {31'd0, rdata_valid}, 32'd0);

        // 6: address wrap modulo storage depth
        writeback(32'h10, d_w, 16'b1111, 4, "t6_wb");
        refill(32'h1010, d_w, "t6_rdwrap");
        refill(32'h0, d_zero, "t6_rd0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
